// File: rtl/door_motor_plant.sv
// Garage door mechanism model: integrates motor drive into a position, drives the
// limit switches, and latches drive/stall faults. Define DOOR_MOTOR_PLANT_OBSTRUCT_EN
// to add the obstruct input that blocks closing travel.
module door_motor_plant #(
  parameter int TRAVEL_STEPS = 100,
  parameter int POS_WIDTH    = 8,
  parameter int PRESCALE     = 4,
  parameter int STALL_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 UP_m,
  input  logic                 DN_m,
  input  logic                 fault_clr,
`ifdef DOOR_MOTOR_PLANT_OBSTRUCT_EN
  input  logic                 obstruct,
`endif
  output logic                 UP_max,
  output logic                 DN_max,
  output logic [POS_WIDTH-1:0] position,
  output logic                 moving,
  output logic                 fault
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {STOPPED, RISING, FALLING, FAULT} state_t;

  state_t                 state_q, state_d, dir_st;
  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic [PW-1:0]          pre_q, pre_d, pre_nx;
  logic [SW-1:0]          stall_q, stall_d;
  logic                   fault_q, fault_d;
  logic                   up_max_q, dn_max_q, moving_q;
  logic                   up_only, dn_only, blocked;

  assign up_only = UP_m & ~DN_m;
  assign dn_only = DN_m & ~UP_m;

  always_comb begin
    blocked = (up_only && pos_q == POS_WIDTH'(TRAVEL_STEPS)) ||
              (dn_only && pos_q == '0);
`ifdef DOOR_MOTOR_PLANT_OBSTRUCT_EN
    // An obstruction only stalls a door that is already closing.
    blocked = blocked || (state_q == FALLING && dn_only && obstruct);
`endif
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pre_d   = pre_q;
    stall_d = '0;
    fault_d = fault_q;
    dir_st  = up_only ? RISING : FALLING;
    pre_nx  = '0;
    if (state_q == FAULT) begin
      pre_d = '0;
      if (fault_clr && !UP_m && !DN_m) begin
        state_d = STOPPED;
        fault_d = 1'b0;
      end
    end else if (UP_m && DN_m) begin
      state_d = FAULT;
      pre_d   = '0;
      fault_d = 1'b1;
    end else if (!UP_m && !DN_m) begin
      state_d = STOPPED;
      pre_d   = '0;
    end else begin
      state_d = dir_st;
      if (blocked) begin
        pre_d   = '0;
        stall_d = stall_q + 1'b1;
        if (stall_d == SW'(STALL_CYCLES)) begin
          state_d = FAULT;
          stall_d = '0;
          fault_d = 1'b1;
        end
      end else begin
        // Entering a direction (start or reversal) discards any partial step.
        pre_nx = (state_q == dir_st) ? pre_q + 1'b1 : PW'(1);
        if (pre_nx == PW'(PRESCALE)) begin
          pre_d = '0;
          pos_d = up_only ? pos_q + 1'b1 : pos_q - 1'b1;
        end else begin
          pre_d = pre_nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STOPPED;
      pos_q    <= '0;
      pre_q    <= '0;
      stall_q  <= '0;
      fault_q  <= 1'b0;
      up_max_q <= 1'b0;
      dn_max_q <= 1'b1;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      pre_q    <= pre_d;
      stall_q  <= stall_d;
      fault_q  <= fault_d;
      up_max_q <= (pos_d == POS_WIDTH'(TRAVEL_STEPS));
      dn_max_q <= (pos_d == '0);
      moving_q <= (state_d == RISING) || (state_d == FALLING);
    end
  end

  assign UP_max   = up_max_q;
  assign DN_max   = dn_max_q;
  assign position = pos_q;
  assign moving   = moving_q;
  assign fault    = fault_q;

endmodule
